// File: rtl/dm_access_unit.sv
// rtl/dm_access_unit.sv - data-memory access stage with posted store buffer and read forwarding
module dm_access_unit #(
    parameter int ADDR_W   = 10,
    parameter int SB_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps_dm_en,
    input  logic        ps_dm_wrt,
    input  logic [15:0] dg_dm_add,
    input  logic [15:0] bc_dt_out,
    output logic [15:0] dm_bc_dt,
    output logic        dm_bc_dt_vld,
    output logic        dm_ps_stall,
    output logic        dm_ps_err,
    output logic [2:0]  dm_sb_cnt
);

    logic [15:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] sb_addr [4];
    logic [15:0]       sb_data [4];
    logic [1:0]        head;
    logic [1:0]        tail;
    logic [2:0]        cnt;

    logic              in_range;
    logic              full;
    logic              acc;
    logic              wr_acc;
    logic              rd_acc;
    logic              err_acc;
    logic              drain;
    logic [ADDR_W-1:0] addr_t;
    logic              fwd_hit;
    logic [15:0]       fwd_data;
    logic [2:0]        pos;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'(SB_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign in_range    = (dg_dm_add >> ADDR_W) == 16'd0;
    assign addr_t      = dg_dm_add[ADDR_W-1:0];
    assign full        = (cnt == 3'(SB_DEPTH));
    assign dm_ps_stall = ps_dm_en & ps_dm_wrt & in_range & full;
    assign acc         = ps_dm_en & ~dm_ps_stall;
    assign wr_acc      = acc & ps_dm_wrt & in_range;
    assign rd_acc      = acc & ~ps_dm_wrt & in_range;
    assign err_acc     = acc & ~in_range;
    // Stalled cycles are idle from the array's point of view, so the head can drain.
    assign drain       = ~acc & (cnt != 3'd0);
    assign dm_sb_cnt   = cnt;

    // Walk entries oldest to youngest so the last match is the newest data.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = 16'd0;
        pos      = 3'd0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            pos = {1'b0, head} + 3'(i);
            if (pos >= 3'(SB_DEPTH))
                pos = pos - 3'(SB_DEPTH);
            if ((3'(i) < cnt) && (sb_addr[pos[1:0]] == addr_t)) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data[pos[1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= 3'd0;
            head         <= 2'd0;
            tail         <= 2'd0;
            dm_bc_dt     <= 16'd0;
            dm_bc_dt_vld <= 1'b0;
            dm_ps_err    <= 1'b0;
        end else begin
            dm_bc_dt_vld <= rd_acc;
            dm_ps_err    <= err_acc;
            if (rd_acc)
                dm_bc_dt <= fwd_hit ? fwd_data : mem[addr_t];
            if (wr_acc) begin
                sb_addr[tail] <= addr_t;
                sb_data[tail] <= bc_dt_out;
                tail          <= nxt(tail);
                cnt           <= cnt + 3'd1;
            end else if (drain) begin
                head <= nxt(head);
                cnt  <= cnt - 3'd1;
            end
        end
    end

    // Array contents survive reset; only the drain is suppressed.
    always_ff @(posedge clk) begin
        if (drain && !rst)
            mem[sb_addr[head]] <= sb_data[head];
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// tb/tb_dm_access_unit.sv - scoreboard bench for dm_access_unit
module tb_dm_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps_dm_en;
    logic        ps_dm_wrt;
    logic [15:0] dg_dm_add;
    logic [15:0] bc_dt_out;
    logic [15:0] dm_bc_dt;
    logic        dm_bc_dt_vld;
    logic        dm_ps_stall;
    logic        dm_ps_err;
    logic [2:0]  dm_sb_cnt;

    typedef struct {
        bit          is_err;
        logic [15:0] data;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    dm_access_unit #(.ADDR_W(10), .SB_DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .ps_dm_en     (ps_dm_en),
        .ps_dm_wrt    (ps_dm_wrt),
        .dg_dm_add    (dg_dm_add),
        .bc_dt_out    (bc_dt_out),
        .dm_bc_dt     (dm_bc_dt),
        .dm_bc_dt_vld (dm_bc_dt_vld),
        .dm_ps_stall  (dm_ps_stall),
        .dm_ps_err    (dm_ps_err),
        .dm_sb_cnt    (dm_sb_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output event must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && (dm_bc_dt_vld || dm_ps_err)) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: vld=%b err=%b data=%h with empty scoreboard",
                         dm_bc_dt_vld, dm_ps_err, dm_bc_dt);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.is_err) begin
                    if (!(dm_ps_err && !dm_bc_dt_vld)) begin
                        bad++;
                        $display("FAIL err_pulse: vld=%b err=%b expected vld=0 err=1",
                                 dm_bc_dt_vld, dm_ps_err);
                    end
                end else if (!(dm_bc_dt_vld && !dm_ps_err && dm_bc_dt === e.data)) begin
                    bad++;
                    $display("FAIL read_data: vld=%b err=%b data=%h expected vld=1 err=0 data=%h",
                             dm_bc_dt_vld, dm_ps_err, dm_bc_dt, e.data);
                end
            end
        end
    end

    task automatic access(input logic en, input logic wrt, input logic [15:0] addr,
                          input logic [15:0] data, input logic exp_stall);
        exp_t e;
        ps_dm_en  = en;
        ps_dm_wrt = wrt;
        dg_dm_add = addr;
        bc_dt_out = data;
        #1;
        chk("stall", {15'd0, dm_ps_stall}, {15'd0, exp_stall});
        if (en && !exp_stall) begin
            if (addr[15:10] != 6'd0) begin
                e.is_err = 1'b1;
                e.data   = 16'd0;
                q.push_back(e);
            end else if (!wrt) begin
                e.is_err = 1'b0;
                e.data   = data;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        access(1'b1, 1'b1, addr, data, 1'b0);
    endtask

    task automatic rd(input logic [15:0] addr, input logic [15:0] exp_data);
        access(1'b1, 1'b0, addr, exp_data, 1'b0);
    endtask

    task automatic idle();
        access(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        ps_dm_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_cnt", {13'd0, dm_sb_cnt}, 16'd0);
        chk("rst_dt", dm_bc_dt, 16'd0);
        chk("rst_vld_err", {14'd0, dm_bc_dt_vld, dm_ps_err}, 16'd0);
    endtask

    initial begin
        rst       = 1'b1;
        ps_dm_en  = 1'b0;
        ps_dm_wrt = 1'b0;
        dg_dm_add = 16'd0;
        bc_dt_out = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Preload array through the buffer, then reset: array must keep its contents.
        wr(16'h0005, 16'h1234); idle();
        wr(16'h0030, 16'h5555); idle();
        wr(16'h0031, 16'h6666); idle();
        chk("preload_cnt", {13'd0, dm_sb_cnt}, 16'd0);
        do_reset();
        rd(16'h0005, 16'h1234);
        chk("read_cnt", {13'd0, dm_sb_cnt}, 16'd0);

        // Forwarding, then drain on one idle cycle.
        wr(16'h0010, 16'hAAAA);
        rd(16'h0010, 16'hAAAA);
        chk("fwd_cnt", {13'd0, dm_sb_cnt}, 16'd1);
        idle();
        chk("drain_cnt", {13'd0, dm_sb_cnt}, 16'd0);
        rd(16'h0010, 16'hAAAA);

        // Youngest duplicate wins, and drain order leaves the newest in the array.
        wr(16'h0020, 16'h0001);
        wr(16'h0020, 16'h0002);
        rd(16'h0020, 16'h0002);
        chk("dup_cnt", {13'd0, dm_sb_cnt}, 16'd2);
        idle(); idle();
        rd(16'h0020, 16'h0002);

        // Full buffer stalls the third write for exactly one cycle.
        wr(16'h0040, 16'h00A1);
        wr(16'h0041, 16'h00A2);
        access(1'b1, 1'b1, 16'h0042, 16'h00A3, 1'b1);
        chk("stall_drain_cnt", {13'd0, dm_sb_cnt}, 16'd1);
        access(1'b1, 1'b1, 16'h0042, 16'h00A3, 1'b0);
        chk("stall_accept_cnt", {13'd0, dm_sb_cnt}, 16'd2);
        idle(); idle();
        chk("stall_empty_cnt", {13'd0, dm_sb_cnt}, 16'd0);
        rd(16'h0040, 16'h00A1);
        rd(16'h0041, 16'h00A2);
        rd(16'h0042, 16'h00A3);

        // Out-of-range accesses: error pulse, no data, no buffer or array effect.
        rd(16'h8000, 16'h0000);
        wr(16'h0050, 16'h0077);
        wr(16'h0400, 16'h9999);
        chk("oor_cnt", {13'd0, dm_sb_cnt}, 16'd1);
        wr(16'h0430, 16'hBEEF);
        chk("oor_cnt2", {13'd0, dm_sb_cnt}, 16'd1);
        rd(16'h0050, 16'h0077);
        idle();
        rd(16'h0030, 16'h5555);

        // Reset with pending writes discards them, including the would-be drain.
        wr(16'h0030, 16'h1111);
        wr(16'h0031, 16'h2222);
        chk("pre_rst_cnt", {13'd0, dm_sb_cnt}, 16'd2);
        do_reset();
        idle(); idle();
        rd(16'h0030, 16'h5555);
        rd(16'h0031, 16'h6666);
        idle();

        begin
            int waited = 0;
            while (q.size() != 0 && waited < 10) begin
                @(posedge clk);
                waited++;
            end
            total++;
            if (q.size() != 0) begin
                bad++;
                $display("FAIL drain_scoreboard: %0d pending expected 0", q.size());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
